// File: rtl/npc_micro_pkg.sv
// Shared micro-command layout and encodings for the decoder table and the
// execution controller.
package npc_micro_pkg;

   localparam int MICRO_LEN  = 14;
   localparam int REGEN_BIT  = 13;
   localparam int PCJEN_BIT  = 12;
   localparam int PCREN_BIT  = 11;
   localparam int MWEN_LSB   = 9;
   localparam int MREN_LSB   = 7;
   localparam int ALUOP_LSB  = 4;
   localparam int UNSIGN_BIT = 3;
   localparam int IMM_LSB    = 0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0, ALU_NE  = 3'd1, ALU_EQ = 3'd2, ALU_LT  = 3'd3,
      ALU_GE  = 3'd4, ALU_AND = 3'd5, ALU_OR = 3'd6, ALU_XOR = 3'd7
   } aluop_e;

   // shared by MREN and MWEN; also the mem_size encoding
   typedef enum logic [1:0] {
      MSZ_NONE = 2'd0, MSZ_B = 2'd1, MSZ_H = 2'd2, MSZ_W = 2'd3
   } msize_e;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0, IMM_I = 3'd1, IMM_S = 3'd2, IMM_SB = 3'd3,
      IMM_U    = 3'd4, IMM_UJ = 3'd7
   } imm_e;

   typedef enum logic [1:0] {
      WSEL_ALU = 2'd0, WSEL_MEM = 2'd1, WSEL_PC4 = 2'd2
   } rf_wsel_e;

   typedef enum logic [2:0] {
      ST_IDLE, ST_EXEC, ST_MEM_REQ, ST_MEM_WAIT, ST_WB, ST_HALT
   } ctrl_state_e;

   function automatic logic f_regen(input logic [MICRO_LEN-1:0] c);
      return c[REGEN_BIT];
   endfunction
   function automatic logic f_pcjen(input logic [MICRO_LEN-1:0] c);
      return c[PCJEN_BIT];
   endfunction
   function automatic logic f_pcren(input logic [MICRO_LEN-1:0] c);
      return c[PCREN_BIT];
   endfunction
   function automatic logic [1:0] f_mwen(input logic [MICRO_LEN-1:0] c);
      return c[MWEN_LSB +: 2];
   endfunction
   function automatic logic [1:0] f_mren(input logic [MICRO_LEN-1:0] c);
      return c[MREN_LSB +: 2];
   endfunction
   function automatic logic [2:0] f_aluop(input logic [MICRO_LEN-1:0] c);
      return c[ALUOP_LSB +: 3];
   endfunction
   function automatic logic f_unsign(input logic [MICRO_LEN-1:0] c);
      return c[UNSIGN_BIT];
   endfunction
   function automatic logic [2:0] f_imm(input logic [MICRO_LEN-1:0] c);
      return c[IMM_LSB +: 3];
   endfunction

endpackage

// File: rtl/micro_exec_ctrl.sv
// Micro execution controller: sequences one decoded instruction through
// EXEC -> (MEM) -> WB and drives ALU, data-memory, regfile and PC controls.
// EBREAK, illegal instructions and memory timeouts park it in HALT.
module micro_exec_ctrl
   import npc_micro_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 dec_valid,
   output logic                 dec_ready,
   input  logic [MICRO_LEN-1:0] micro_cmd,
   input  logic                 dec_hit,
   input  logic                 alu_cmp,
   output logic [2:0]           alu_op,
   output logic                 alu_a_pc,
   output logic                 alu_b_imm,
   output logic [2:0]           imm_type,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [1:0]           mem_size,
   output logic                 mem_unsigned,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   output logic                 rf_wen,
   output logic [1:0]           rf_wsel,
   output logic                 pc_we,
   output logic                 pc_sel,
   output logic                 halted,
   output logic                 illegal,
   output logic                 mem_timeout
);

   ctrl_state_e          state_q, state_d;
   logic [MICRO_LEN-1:0] cmd_q, cmd_d;
   logic                 taken_q, taken_d;
   logic [7:0]           tcnt_q, tcnt_d, tcnt_inc;
   logic                 halted_q, halted_d;
   logic                 illegal_q, illegal_d;
   logic                 tmo_q, tmo_d;
   logic                 tmo_hit, cmd_is_mem, in_is_mem;

   assign tcnt_inc   = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
   assign tmo_hit    = (MEM_TIMEOUT != 0) && ((32'(tcnt_q) + 32'd1) >= MEM_TIMEOUT);
   assign cmd_is_mem = (f_mren(cmd_q) != MSZ_NONE) || (f_mwen(cmd_q) != MSZ_NONE);
   assign in_is_mem  = (f_mren(micro_cmd) != MSZ_NONE) && (f_mwen(micro_cmd) != MSZ_NONE);

   assign halted      = halted_q;
   assign illegal     = illegal_q;
   assign mem_timeout = tmo_q;

   // state, latched command and sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= '0;
         taken_q   <= 1'b0;
         tcnt_q    <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         taken_q   <= taken_d;
         tcnt_q    <= tcnt_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         tmo_q     <= tmo_d;
      end
   end

   // next state and per-state control outputs, all sourced from cmd_q
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      taken_d      = taken_q;
      tcnt_d       = tcnt_q;
      halted_d     = halted_q;
      illegal_d    = illegal_q;
      tmo_d        = tmo_q;
      dec_ready    = 1'b0;
      alu_op       = '0;
      alu_a_pc     = 1'b0;
      alu_b_imm    = 1'b0;
      imm_type     = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_size     = '0;
      mem_unsigned = 1'b0;
      rf_wen       = 1'b0;
      rf_wsel      = WSEL_ALU;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dec_ready = 1'b1;
            if (dec_valid) begin
               cmd_d = micro_cmd;
               if (!dec_hit || in_is_mem) begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end else if (micro_cmd == '0) begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            alu_op    = f_aluop(cmd_q);
            alu_a_pc  = f_pcren(cmd_q);
            alu_b_imm = (f_imm(cmd_q) != IMM_NONE) && (f_imm(cmd_q) != IMM_SB);
            imm_type  = f_imm(cmd_q);
            taken_d   = alu_cmp;
            if (cmd_is_mem) begin
               state_d = ST_MEM_REQ;
               tcnt_d  = '0;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_MEM_REQ: begin
            mem_req      = 1'b1;
            mem_we       = (f_mwen(cmd_q) != MSZ_NONE);
            mem_size     = mem_we ? f_mwen(cmd_q) : f_mren(cmd_q);
            mem_unsigned = f_unsign(cmd_q);
            tcnt_d       = tcnt_inc;
            // a grant on the last allowed cycle still wins over the timeout
            if (mem_gnt) begin
               state_d = mem_we ? ST_WB : ST_MEM_WAIT;
            end else if (tmo_hit) begin
               state_d = ST_HALT;
               tmo_d   = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            mem_unsigned = f_unsign(cmd_q);
            tcnt_d       = tcnt_inc;
            if (mem_rvalid) begin
               state_d = ST_WB;
            end else if (tmo_hit) begin
               state_d = ST_HALT;
               tmo_d   = 1'b1;
            end
         end
         ST_WB: begin
            pc_we   = 1'b1;
            rf_wen  = f_regen(cmd_q);
            if (f_pcjen(cmd_q) && f_regen(cmd_q))  rf_wsel = WSEL_PC4;
            else if (f_mren(cmd_q) != MSZ_NONE)     rf_wsel = WSEL_MEM;
            pc_sel  = f_pcjen(cmd_q) && ((f_imm(cmd_q) != IMM_SB) || taken_q);
            state_d = ST_IDLE;
         end
         ST_HALT: ;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_micro_exec_ctrl.sv
// Directed bench for micro_exec_ctrl: per-cycle vector table for the normal
// instruction flows, hand sequences for halt, reset and timeout cases.
module tb_micro_exec_ctrl;
   import npc_micro_pkg::*;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        dec_valid = 1'b0, dec_hit = 1'b0, alu_cmp = 1'b0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [13:0] micro_cmd = '0;
   logic        dec_ready, alu_a_pc, alu_b_imm, mem_req, mem_we, mem_unsigned;
   logic        rf_wen, pc_we, pc_sel, halted, illegal, mem_timeout;
   logic [2:0]  alu_op, imm_type;
   logic [1:0]  mem_size, rf_wsel;

   int nvec = 0, nbad = 0;

   typedef struct {
      string       nm;
      int          v, cmd, h, cmp, g, rv;
      logic [20:0] exp;
   } vec_t;
   vec_t tbl[$];

   micro_exec_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .micro_cmd(micro_cmd), .dec_hit(dec_hit), .alu_cmp(alu_cmp),
      .alu_op(alu_op), .alu_a_pc(alu_a_pc), .alu_b_imm(alu_b_imm),
      .imm_type(imm_type), .mem_req(mem_req), .mem_we(mem_we),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .rf_wen(rf_wen), .rf_wsel(rf_wsel),
      .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted), .illegal(illegal),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [20:0] outs();
      return {dec_ready, mem_req, mem_we, mem_size, rf_wen, rf_wsel, pc_we, pc_sel,
              alu_op, alu_a_pc, alu_b_imm, imm_type, halted, illegal, mem_timeout};
   endfunction

   // inputs | expected: rdy req we sz wen wsel pcwe pcsel aop apc bimm imm (flags 0)
   task automatic row(string nm, int v, int c, int h, int cmp, int g, int rv,
                      int rdy, int req, int we, int sz, int wen, int wsel, int pcwe,
                      int pcsel, int aop, int apc, int bimm, int imm);
      vec_t e;
      e.nm = nm; e.v = v; e.cmd = c; e.h = h; e.cmp = cmp; e.g = g; e.rv = rv;
      e.exp = {1'(rdy), 1'(req), 1'(we), 2'(sz), 1'(wen), 2'(wsel), 1'(pcwe),
               1'(pcsel), 3'(aop), 1'(apc), 1'(bimm), 3'(imm), 3'b000};
      tbl.push_back(e);
   endtask

   task automatic drive(int v, int c, int h, int cmp, int g, int rv);
      dec_valid  = 1'(v);
      micro_cmd  = 14'(c);
      dec_hit    = 1'(h);
      alu_cmp    = 1'(cmp);
      mem_gnt    = 1'(g);
      mem_rvalid = 1'(rv);
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // ADDI: WB at cycle 2; micro_cmd garbage after transfer must not leak
      row("addi_idle", 1,'h2001,1,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("addi_exec", 0,'h3fff,1,0,0,0, 0,0,0,0,0,0,0,0, 0,0,1,1);
      row("addi_wb",   0,'h3fff,0,0,0,0, 0,0,0,0,1,0,1,0, 0,0,0,0);
      // LW: gnt c2 (rvalid there ignored), rvalid c4, WB c5
      row("lw_idle",   1,'h2181,1,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("lw_exec",   0,0,0,0,0,0,      0,0,0,0,0,0,0,0, 0,0,1,1);
      row("lw_req",    0,0,0,0,1,1,      0,1,0,3,0,0,0,0, 0,0,0,0);
      row("lw_wait",   0,0,0,0,0,0,      0,0,0,0,0,0,0,0, 0,0,0,0);
      row("lw_wait_rv",0,0,0,0,0,1,      0,0,0,0,0,0,0,0, 0,0,0,0);
      row("lw_wb",     0,0,0,0,0,0,      0,0,0,0,1,1,1,0, 0,0,0,0);
      // SW: gnt on 4th request cycle (also last cycle before timeout)
      row("sw_idle",   1,'h0602,1,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("sw_exec",   0,0,0,0,0,0,      0,0,0,0,0,0,0,0, 0,0,1,2);
      row("sw_req0",   0,0,0,0,0,0,      0,1,1,3,0,0,0,0, 0,0,0,0);
      row("sw_req1",   0,0,0,0,0,0,      0,1,1,3,0,0,0,0, 0,0,0,0);
      row("sw_req2",   0,0,0,0,0,0,      0,1,1,3,0,0,0,0, 0,0,0,0);
      row("sw_req3",   0,0,0,0,1,0,      0,1,1,3,0,0,0,0, 0,0,0,0);
      row("sw_wb",     0,0,0,0,0,0,      0,0,0,0,0,0,1,0, 0,0,0,0);
      // BNE not taken (cmp high only outside EXEC), then taken
      row("bne0_idle", 1,'h1813,1,1,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("bne0_exec", 0,0,0,0,0,0,      0,0,0,0,0,0,0,0, 1,1,0,3);
      row("bne0_wb",   0,0,0,1,0,0,      0,0,0,0,0,0,1,0, 0,0,0,0);
      row("bne1_idle", 1,'h1813,1,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("bne1_exec", 0,0,0,1,0,0,      0,0,0,0,0,0,0,0, 1,1,0,3);
      row("bne1_wb",   0,0,0,0,0,0,      0,0,0,0,0,0,1,1, 0,0,0,0);
      // JAL: link to PC+4, jump
      row("jal_idle",  1,'h3807,1,0,0,0, 1,0,0,0,0,0,0,0, 0,0,0,0);
      row("jal_exec",  0,0,0,0,0,0,      0,0,0,0,0,0,0,0, 0,1,1,7);
      row("jal_wb",    0,0,0,0,0,0,      0,0,0,0,1,2,1,1, 0,0,0,0);
      row("end_idle",  0,0,0,0,0,0,      1,0,0,0,0,0,0,0, 0,0,0,0);

      // in reset: only dec_ready high
      @(negedge clk);
      chk("in_reset", 32'(outs()), 32'h100000);
      @(posedge clk); #1 rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].cmd, tbl[i].h, tbl[i].cmp, tbl[i].g, tbl[i].rv);
         @(negedge clk);
         chk(tbl[i].nm, 32'(outs()), 32'(tbl[i].exp));
         tick();
      end

      // decode miss: {rdy, illegal, halted, pc_we, rf_wen}
      drive(1, 'h2001, 0, 0, 0, 0); tick();
      drive(1, 'h2001, 1, 0, 0, 0);
      @(negedge clk);
      chk("ill_miss", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h08);
      repeat (3) tick();
      @(negedge clk);
      chk("ill_sticky", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h08);
      do_reset();
      @(negedge clk);
      chk("ill_rst", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h10);
      tick();

      // MREN and MWEN both set
      drive(1, 'h0380, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("ill_mrw", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h08);
      do_reset();

      // EBREAK
      drive(1, 'h0000, 1, 0, 0, 0); tick();
      drive(1, 'h2001, 1, 0, 0, 0);
      @(negedge clk);
      chk("ebreak", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h04);
      repeat (2) tick();
      @(negedge clk);
      chk("ebreak_sticky", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h04);
      do_reset();
      @(negedge clk);
      chk("ebreak_rst", 32'({dec_ready, illegal, halted, pc_we, rf_wen}), 32'h10);
      tick();

      // async reset during MEM_REQ drops mem_req at once
      drive(1, 'h2181, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0); tick();
      @(negedge clk);
      chk("rst_req_pre", 32'(mem_req), 32'd1);
      #1 rst_n = 1'b0;
      #1 chk("rst_req_drop", 32'({mem_req, dec_ready}), 32'h1);
      @(posedge clk); #1 rst_n = 1'b1;

      // timeout with MEM_TIMEOUT=4: four request cycles, then HALT
      drive(1, 'h2181, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0); tick();
      repeat (3) tick();
      @(negedge clk);
      chk("tmo_last_req", 32'({mem_req, mem_timeout}), 32'h2);
      tick();
      @(negedge clk);
      chk("tmo_halt", 32'({mem_req, mem_timeout, dec_ready, halted, illegal}), 32'h08);
      do_reset();
      @(negedge clk);
      chk("tmo_rst", 32'({mem_timeout, dec_ready}), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
